// File: rtl/output_buffer_if.sv
// Vector-in / element-out bundle of the output buffer.
// The slave modport is the buffer; the master modport is the host/pipeline side.
interface output_buffer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int OB_DEPTH   = 4
);
    logic                               valid_in;
    logic                               eof_in;
    logic [DATA_WIDTH-1:0]              vector_in [N];
    logic                               ready_out;
    logic                               element_valid_out;
    logic [DATA_WIDTH-1:0]              element_out;
    logic                               element_last_out;
    logic                               element_eof_out;
    logic                               element_ready_in;
    logic [$clog2(OB_DEPTH+1)-1:0]      occupancy_out;
    logic                               overflow_out;

    modport slave (
        input  valid_in, eof_in, vector_in, element_ready_in,
        output ready_out, element_valid_out, element_out, element_last_out,
        output element_eof_out, occupancy_out, overflow_out
    );

    modport master (
        output valid_in, eof_in, vector_in, element_ready_in,
        input  ready_out, element_valid_out, element_out, element_last_out,
        input  element_eof_out, occupancy_out, overflow_out
    );
endinterface

// File: rtl/output_buffer.sv
// Vector FIFO feeding a lane serializer: N-lane vectors in, one element per
// handshake out (lane 0 first); full-FIFO pushes are dropped and flagged.
module output_buffer #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int OB_DEPTH   = 4
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    output_buffer_if.slave bus
);
    localparam int PW = (OB_DEPTH > 1) ? $clog2(OB_DEPTH) : 1;
    localparam int CW = $clog2(OB_DEPTH + 1);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e                state_q;
    logic [LW-1:0]         lane_q;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic                  overflow_q;

    logic [DATA_WIDTH-1:0] mem_q  [OB_DEPTH][N];
    logic                  eof_mem_q [OB_DEPTH];
    logic [DATA_WIDTH-1:0] hold_q [N];
    logic                  hold_eof_q;

    logic ready, push, pop, last_hs;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign ready   = (count_q != CW'(OB_DEPTH));
    assign push    = bus.valid_in && ready;
    assign last_hs = (state_q == SEND) && bus.element_ready_in && (lane_q == LW'(N - 1));
    assign pop     = (count_q != '0) && ((state_q == IDLE) || last_hs);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
        head_d = head_q;
        if (pop)
            head_d = (head_q == PW'(OB_DEPTH - 1)) ? '0 : head_q + 1'b1;
        tail_d = tail_q;
        if (push)
            tail_d = (tail_q == PW'(OB_DEPTH - 1)) ? '0 : tail_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (bus.valid_in && !ready)
                overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        lane_q  <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (bus.element_ready_in) begin
                        if (lane_q != LW'(N - 1))
                            lane_q <= lane_q + 1'b1;
                        else if (pop)
                            lane_q <= '0;
                        else
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Payload storage carries no reset; every output read of it is gated by state.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[tail_q]     <= bus.vector_in;
            eof_mem_q[tail_q] <= bus.eof_in;
        end
        if (pop) begin
            hold_q     <= mem_q[head_q];
            hold_eof_q <= eof_mem_q[head_q];
        end
    end

    assign bus.ready_out         = ready;
    assign bus.element_valid_out = (state_q == SEND);
    assign bus.element_out       = (state_q == SEND) ? hold_q[lane_q] : '0;
    assign bus.element_last_out  = (state_q == SEND) && (lane_q == LW'(N - 1));
    assign bus.element_eof_out   = bus.element_last_out && hold_eof_q;
    assign bus.occupancy_out     = count_q;
    assign bus.overflow_out      = overflow_q;
endmodule

// File: tb/tb_output_buffer.sv
// Bench for output_buffer (N=4, 32-bit lanes, depth 4): a scoreboard of
// expected elements is filled on accepted pushes and drained on host handshakes.
module tb_output_buffer;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int D  = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic          eof;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    output_buffer_if #(.N(N), .DATA_WIDTH(DW), .OB_DEPTH(D)) ob_if ();

    output_buffer #(.N(N), .DATA_WIDTH(DW), .OB_DEPTH(D)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ob_if)
    );

    always #5 clk = ~clk;

    // Host side of the scoreboard: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ob_if.element_valid_out && ob_if.element_ready_in) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_element got=%0h", ob_if.element_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ob_if.element_out !== e.d || ob_if.element_last_out !== e.last ||
                    ob_if.element_eof_out !== e.eof) begin
                    failures++;
                    $display("FAIL element got=%0h/last%0b/eof%0b exp=%0h/last%0b/eof%0b",
                             ob_if.element_out, ob_if.element_last_out, ob_if.element_eof_out,
                             e.d, e.last, e.eof);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input logic [DW-1:0] base, input logic eof, input bit accept);
        for (int i = 0; i < N; i++) begin
            ob_if.vector_in[i] = base + DW'(i);
            if (accept) sb.push_back('{base + DW'(i), (i == N - 1), eof && (i == N - 1)});
        end
        ob_if.eof_in   = eof;
        ob_if.valid_in = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d left exp=0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ob_if.valid_in = 1'b0;
        ob_if.element_ready_in = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        ob_if.valid_in = 1'b0;
        ob_if.eof_in = 1'b0;
        ob_if.element_ready_in = 1'b0;
        for (int i = 0; i < N; i++) ob_if.vector_in[i] = '0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (ob_if.element_valid_out !== 1'b0 || ob_if.ready_out !== 1'b1 ||
            ob_if.element_out !== '0 || ob_if.element_last_out !== 1'b0 ||
            ob_if.element_eof_out !== 1'b0 || ob_if.occupancy_out !== 3'd0 ||
            ob_if.overflow_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=v%0b r%0b e%0h occ%0d ovf%0b exp=v0 r1 e0 occ0 ovf0",
                     ob_if.element_valid_out, ob_if.ready_out, ob_if.element_out,
                     ob_if.occupancy_out, ob_if.overflow_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ob_if.element_ready_in = 1'b1;
        drive_vec(32'h10, 1'b1, 1'b1);
        tick();
        ob_if.valid_in = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (ob_if.element_valid_out !== (c >= 2 && c <= 5) ||
                ob_if.element_last_out !== (c == 5) || ob_if.element_eof_out !== (c == 5)) begin
                failures++;
                $display("FAIL single_c%0d got=v%0b l%0b e%0b exp=v%0b l%0b e%0b", c,
                         ob_if.element_valid_out, ob_if.element_last_out, ob_if.element_eof_out,
                         (c >= 2 && c <= 5), (c == 5), (c == 5));
            end
            tick();
        end
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_occ;
        ob_if.element_ready_in = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            if (c < 3) drive_vec(32'h40 + DW'(c * 16), (c == 2), 1'b1);
            else ob_if.valid_in = 1'b0;
            @(negedge clk);
            checks++;
            if (ob_if.element_valid_out !== (c >= 2 && c <= 13)) begin
                failures++;
                $display("FAIL b2b_valid_c%0d got=%0b exp=%0b", c, ob_if.element_valid_out,
                         (c >= 2 && c <= 13));
            end
            if (c == 1 || c == 3 || c == 5 || c == 6 || c == 10) begin
                case (c)
                    1: exp_occ = 3'd1;
                    3: exp_occ = 3'd2;
                    5: exp_occ = 3'd2;
                    6: exp_occ = 3'd1;
                    default: exp_occ = 3'd0;
                endcase
                checks++;
                if (ob_if.occupancy_out !== exp_occ) begin
                    failures++;
                    $display("FAIL b2b_occ_c%0d got=%0d exp=%0d", c, ob_if.occupancy_out, exp_occ);
                end
            end
            tick();
        end
        wait_drain("b2b");
    endtask

    task automatic test_backpressure();
        for (int c = 0; c <= 11; c++) begin
            if (c == 0) drive_vec(32'h20, 1'b0, 1'b1);
            else ob_if.valid_in = 1'b0;
            ob_if.element_ready_in = !(c >= 4 && c <= 8);
            @(negedge clk);
            if (c >= 4 && c <= 9) begin
                checks++;
                if (ob_if.element_valid_out !== 1'b1 || ob_if.element_out !== 32'h22) begin
                    failures++;
                    $display("FAIL bp_hold_c%0d got=v%0b %0h exp=v1 22", c,
                             ob_if.element_valid_out, ob_if.element_out);
                end
            end
            if (c == 10) begin
                checks++;
                if (ob_if.element_out !== 32'h23 || ob_if.element_last_out !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_lane3 got=%0h l%0b exp=23 l1", ob_if.element_out,
                             ob_if.element_last_out);
                end
            end
            if (c == 11) begin
                checks++;
                if (ob_if.element_valid_out !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_idle got=%0b exp=0", ob_if.element_valid_out);
                end
            end
            tick();
        end
        wait_drain("bp");
    endtask

    task automatic test_overflow();
        ob_if.element_ready_in = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            drive_vec(32'h80 + DW'(c * 16), (c == 4), (c < 5));
            @(negedge clk);
            checks++;
            if (ob_if.ready_out !== (c != 5)) begin
                failures++;
                $display("FAIL ovf_ready_c%0d got=%0b exp=%0b", c, ob_if.ready_out, (c != 5));
            end
            tick();
        end
        ob_if.valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (ob_if.overflow_out !== 1'b1 || ob_if.occupancy_out !== 3'd4) begin
            failures++;
            $display("FAIL ovf_state got=ovf%0b occ%0d exp=ovf1 occ4", ob_if.overflow_out,
                     ob_if.occupancy_out);
        end
        ob_if.element_ready_in = 1'b1;
        wait_drain("ovf");
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (ob_if.element_valid_out !== 1'b0 || ob_if.overflow_out !== 1'b1) begin
            failures++;
            $display("FAIL ovf_after got=v%0b ovf%0b exp=v0 ovf1", ob_if.element_valid_out,
                     ob_if.overflow_out);
        end
        tick();
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c < 5) drive_vec(32'hA0 + DW'(c * 16), 1'b0, 1'b1);
            else if (c == 8) drive_vec(32'h990, 1'b1, 1'b0);
            else ob_if.valid_in = 1'b0;
            ob_if.element_ready_in = (c >= 5);
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if (ob_if.ready_out !== 1'b0 || ob_if.element_last_out !== 1'b1 ||
                    ob_if.overflow_out !== 1'b0) begin
                    failures++;
                    $display("FAIL fullpop_edge got=r%0b l%0b ovf%0b exp=r0 l1 ovf0",
                             ob_if.ready_out, ob_if.element_last_out, ob_if.overflow_out);
                end
            end
            tick();
        end
        ob_if.valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (ob_if.occupancy_out !== 3'(D - 1) || ob_if.overflow_out !== 1'b1) begin
            failures++;
            $display("FAIL fullpop_after got=occ%0d ovf%0b exp=occ%0d ovf1",
                     ob_if.occupancy_out, ob_if.overflow_out, D - 1);
        end
        wait_drain("fullpop");
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        ob_if.element_ready_in = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            if (c == 0) drive_vec(32'h30, 1'b1, 1'b1);
            else ob_if.valid_in = 1'b0;
            tick();
        end
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (ob_if.element_valid_out !== 1'b0 || ob_if.ready_out !== 1'b1 ||
            ob_if.element_out !== '0 || ob_if.element_last_out !== 1'b0 ||
            ob_if.occupancy_out !== 3'd0 || ob_if.overflow_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got=v%0b r%0b e%0h occ%0d ovf%0b exp=v0 r1 e0 occ0 ovf0",
                     ob_if.element_valid_out, ob_if.ready_out, ob_if.element_out,
                     ob_if.occupancy_out, ob_if.overflow_out);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (ob_if.element_valid_out !== 1'b0) begin
                failures++;
                $display("FAIL midrst_stale_c%0d got=%0b exp=0", c, ob_if.element_valid_out);
            end
        end
        tick();
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Transmit-side counterpart of the input buffer: accepts N-lane vectors (valid/eof) from the filter/packing pipeline and stores them in an OB_DEPTH-entry FIFO.
- Serializes each vector to a host-facing stream, one DATA_WIDTH element per cycle, lane 0 first.
- The host stream uses a valid/ready handshake.
- Drops input on overflow and records it in a sticky flag.

Parameters:
- N, 8, lanes per vector
- DATA_WIDTH, 32, bits per lane element
- OB_DEPTH, 4, FIFO entries (vectors); any value >= 2

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- valid_in  input  1  vector_in/eof_in valid this cycle
- eof_in  input  1  vector is the last of a frame
- vector_in  input  DATA_WIDTH x N  unpacked array [N-1:0]
- ready_out  output  1  FIFO not full; registered
- element_valid_out  output  1  element_out valid
- element_out  output  DATA_WIDTH  current lane element
- element_last_out  output  1  element is lane N-1 of its vector
- element_eof_out  output  1  element_last_out and vector carried eof
- element_ready_in  input  1  host accepts the element this cycle
- occupancy_out  output  $clog2(OB_DEPTH+1)  FIFO entries held, excluding the vector being serialized
- overflow_out  output  1  sticky: a valid_in was dropped

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, except ready_out = 1.
  - FIFO pointers and count = 0; FSM = IDLE; lane_idx = 0.
  - Reset mid-operation discards the partial vector and all FIFO contents immediately.
- Push:
  - Occurs when valid_in && ready_out: vector_in and eof_in are written at the tail, and the tail advances with wrap from OB_DEPTH-1 to 0.
  - When valid_in && !ready_out, the vector is dropped and overflow_out is set; overflow_out is cleared only by reset.
- ready_out = (count != OB_DEPTH), computed from the registered count. A pop in the same cycle does not rescue a push while full; that push is dropped.
- Pop: the head is copied into an N-lane holding register plus an eof bit, the head advances with wrap, and count decrements.
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - Push only: count + 1.
  - Pop only: count - 1.
- occupancy_out = count.
- FSM IDLE:
  - element_valid_out = 0.
  - If count != 0: pop, lane_idx <= 0, go to SEND.
- FSM SEND:
  - element_valid_out = 1; element_out = hold[lane_idx].
  - element_last_out = (lane_idx == N-1); element_eof_out = element_last_out && held eof.
  - Outputs stay stable while element_ready_in = 0.
  - On element_ready_in with lane_idx < N-1: lane_idx + 1.
  - On element_ready_in with lane_idx == N-1: if count != 0, pop, lane_idx <= 0 and stay in SEND (back-to-back, no bubble); otherwise go to IDLE.
- Latency: valid_in sampled at the end of cycle c into an empty FIFO with FSM in IDLE → element_valid_out high in cycle c+2 with lane 0.
- Throughput: one vector per N cycles when element_ready_in is held at 1. A sustained input rate above 1/N overflows after OB_DEPTH+1 vectors are buffered.
- eof does not gate or flush anything; it is carried through as data.

Test Plan:
- Single vector (N=4, DW=32, depth 4): push {lane0..3 = 0x10,0x11,0x12,0x13} with eof = 1 in cycle 0, element_ready_in held at 1 → valid in cycles 2-5 with elements 0x10..0x13; element_last_out and element_eof_out high only in cycle 5; back to IDLE in cycle 6.
- Back-to-back: push 3 vectors in consecutive cycles with ready = 1 → 12 consecutive valid cycles with no bubble; occupancy_out goes 1, 2, 2, then decrements at each vector boundary to 0.
- Backpressure: during SEND, hold element_ready_in = 0 for 5 cycles at lane 2 → element_out is held at lane 2's value and element_valid_out stays 1; lane 3 appears the cycle after ready returns.
- Overflow: with element_ready_in = 0, push 6 vectors → 1 is held, 4 are queued, ready_out = 0 after the 5th push, the 6th is dropped and overflow_out = 1. Release ready → exactly 5 vectors emerge in order; overflow_out remains 1.
- Full with simultaneous pop: in a full cycle where the last lane handshakes, also assert valid_in → that vector is dropped, overflow_out is set, and count = OB_DEPTH-1 next cycle.
- Reset mid-SEND: assert rst_n_in = 0 at lane 1 → all outputs read 0 and ready_out = 1 while reset is low; after release, no stale element is emitted and a new push behaves as in the single-vector case.
